alu_program_sequencer: RTL and testbench
========================================

// Module: alu_program_sequencer
// PURPOSE
// - Holds a short program of 16-bit ALU instructions and issues them one per cycle to the
//   16x8 memory/ALU datapath, whose instruction input it drives directly.
// - Replaces direct testbench driving: the host loads the program, pulses start, waits for done.
// - The datapath executes on every posedge, so the block always drives a harmless NOP when not issuing.
// PARAMETERS
// - PROG_DEPTH  16  program slots; power of two, 2..256
// - PC_W        4   $clog2(PROG_DEPTH); pc and prog_addr width
// PORTS
// - clk          in   1     clock; all state changes on posedge
// - rst_n        in   1     asynchronous, active-low reset
// - prog_we      in   1     program write strobe
// - prog_addr    in   PC_W  program write slot
// - prog_wdata   in   16    instruction to store ([15:12] opcode, [11:0] operands)
// - prog_len     in   PC_W+1  instructions to run, 0..PROG_DEPTH; sampled with start
// - start        in   1     begin a run; honoured only in IDLE
// - loop_en      in   1     sampled with start; 1 = wrap pc to 0 after the last slot and keep running
// - hold         in   1     stall: issue NOP, freeze pc
// - abort        in   1     end the run; return to IDLE
// - instr_out    out  16    registered instruction to the datapath
// - instr_valid  out  1     instr_out is a program word (not a NOP filler)
// - pc           out  PC_W  slot currently issued
// - busy         out  1     state is RUN
// - done         out  1     one-cycle pulse at the end of a run
// - halted       out  1     run ended on HALT opcode; sticky until next start
// - prog_err     out  1     one-cycle pulse when prog_we is rejected
// BEHAVIOUR
// - Reset (async): state=IDLE; instr_out=NOP_INSTR (16'h5000); every program slot=NOP_INSTR;
//   pc=0; the flags instr_valid, busy, done, halted and prog_err are all 0.
// - Opcodes 5/6/7 are datapath no-ops. NOP_INSTR uses opcode 5. Opcode 7 is HALT for this block.
// - States: IDLE -> RUN -> DONE -> IDLE. Each state is one registered stage.
// - IDLE
//   - prog_we writes slot prog_addr.
//   - start, prog_len>0: capture len/loop; pc=0; next state RUN.
//   - start, prog_len=0: next state DONE; nothing is issued.
// - RUN, each cycle without hold
//   - instr_out=prog[pc], instr_valid=1, then pc++.
//   - After slot len-1: loop_en=1 sets pc to 0; otherwise next state is DONE.
//   - Latency: start sampled at edge T; first word valid after T+1; last word after T+len.
//   - done is high for one cycle after T+len+1.
// - HALT: when prog[pc][15:12]==7 in RUN, issue NOP_INSTR with instr_valid=0.
//   - Set halted=1 and go to DONE. The halt word is never marked valid.
// - hold=1 in RUN: instr_out=NOP_INSTR, instr_valid=0, pc unchanged. hold in IDLE/DONE: no effect.
// - abort: highest priority, beats hold and HALT.
//   - In RUN, next state is IDLE: instr_out=NOP_INSTR, instr_valid=0, pc=0.
//   - No done pulse. halted is not set.
// - DONE: lasts one cycle (done=1, NOP out), then IDLE. start in DONE is ignored.
// - prog_we outside IDLE: write dropped, prog_err pulses. start while busy: ignored, no error.
// - prog_we and start in the same IDLE cycle: the write commits first; the run sees the new word.
// - pc increments modulo PROG_DEPTH. prog_len>PROG_DEPTH saturates to PROG_DEPTH.
// - Reset mid-run: immediate IDLE, outputs take their reset values, the program is cleared.
// STRUCTURE
// - Package alu_seq_pkg:
//   - seq_state_t enum {IDLE,RUN,DONE}
//   - OPC_HALT=4'h7, NOP_INSTR=16'h5000, opcode constants 0..15 shared with the datapath.
// - Sub-module seq_prog_store: PROG_DEPTH x 16 register array.
//   - Async-reset to NOP_INSTR; one write port, one combinational read port indexed by pc.
// - Top level holds the FSM, pc/len counters and output registers.
// TESTING
// - Load slot0=16'h0051, slot1=16'h0032, slot2=16'hB013; start len=3
//   -> words issued after T+1..T+3 in order; done after T+4; datapath mem[3]=8'h08.
// - Slot1=16'h7000, len=4 -> only slot0 valid; halted=1; done after T+3; pc never reaches 2.
// - hold high on 2nd RUN cycle for 3 cycles, len=3
//   -> 3 NOP cycles with instr_valid=0; pc frozen at 1; done after T+7.
// - loop_en=1, len=2 -> slots 0,1,0,1... issued; abort after 5 issues
//   -> IDLE next cycle, pc=0, no done.
// - prog_we during RUN -> prog_err pulse; rerun shows the old word.
//   start with prog_len=0 -> done after T+1, no valid.
// - rst_n low mid-run -> outputs read NOP/0 immediately; a post-reset run issues only NOP words.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU program sequencer and the 16x8 memory/ALU datapath.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam logic [15:0] NOP_INSTR = 16'h5000;

    localparam logic [3:0] OPC_0 = 4'h0;
    localparam logic [3:0] OPC_1 = 4'h1;
    localparam logic [3:0] OPC_2 = 4'h2;
    localparam logic [3:0] OPC_3 = 4'h3;
    localparam logic [3:0] OPC_4 = 4'h4;
    localparam logic [3:0] OPC_5 = 4'h5;
    localparam logic [3:0] OPC_6 = 4'h6;
    localparam logic [3:0] OPC_7 = 4'h7;
    localparam logic [3:0] OPC_8 = 4'h8;
    localparam logic [3:0] OPC_9 = 4'h9;
    localparam logic [3:0] OPC_A = 4'hA;
    localparam logic [3:0] OPC_B = 4'hB;
    localparam logic [3:0] OPC_C = 4'hC;
    localparam logic [3:0] OPC_D = 4'hD;
    localparam logic [3:0] OPC_E = 4'hE;
    localparam logic [3:0] OPC_F = 4'hF;

    // Opcodes 5/6/7 are no-ops in the datapath; 7 doubles as HALT for the sequencer.
    localparam logic [3:0] OPC_NOP  = OPC_5;
    localparam logic [3:0] OPC_HALT = OPC_7;

endpackage

// File: rtl/seq_prog_store.sv
// Program memory: PROG_DEPTH x 16 registers, one write port, combinational read by pc.
module seq_prog_store
    import alu_seq_pkg::*;
#(
    parameter int unsigned PROG_DEPTH = 16,
    parameter int unsigned PC_W       = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_we,
    input  logic [PC_W-1:0] i_waddr,
    input  logic [15:0]     i_wdata,
    input  logic [PC_W-1:0] i_raddr,
    output logic [15:0]     o_rdata
);

    logic [15:0] r_mem [PROG_DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(PROG_DEPTH); i++) begin
                r_mem[i] <= NOP_INSTR;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_program_sequencer.sv
// Issues a stored program of 16-bit ALU instructions one per cycle, filling idle cycles with NOPs.
module alu_program_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned PROG_DEPTH = 16,
    parameter int unsigned PC_W       = $clog2(PROG_DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_prog_we,
    input  logic [PC_W-1:0] i_prog_addr,
    input  logic [15:0]     i_prog_wdata,
    input  logic [PC_W:0]   i_prog_len,
    input  logic            i_start,
    input  logic            i_loop_en,
    input  logic            i_hold,
    input  logic            i_abort,
    output logic [15:0]     o_instr_out,
    output logic            o_instr_valid,
    output logic [PC_W-1:0] o_pc,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_halted,
    output logic            o_prog_err
);

    localparam logic [1:0]    S_IDLE  = IDLE;
    localparam logic [1:0]    S_RUN   = RUN;
    localparam logic [1:0]    S_DONE  = DONE;
    localparam logic [PC_W:0] LEN_MAX = PROG_DEPTH[PC_W:0];
    localparam logic [PC_W:0] LEN_ONE = {{PC_W{1'b0}}, 1'b1};
    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [1:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W:0]   r_len;
    logic            r_loop;
    logic [15:0]     r_instr;
    logic            r_valid;
    logic            r_done;
    logic            r_halted;
    logic            r_err;

    logic [1:0]      w_state_n;
    logic [PC_W-1:0] w_pc_n;
    logic [PC_W:0]   w_len_n;
    logic            w_loop_n;
    logic [15:0]     w_instr_n;
    logic            w_valid_n;
    logic            w_done_n;
    logic            w_halted_n;
    logic            w_err_n;

    logic            w_we;
    logic [15:0]     w_rdata;
    logic [PC_W:0]   w_len_sat;
    logic            w_last;

    assign w_we      = i_prog_we && (r_state == S_IDLE);
    assign w_len_sat = (i_prog_len > LEN_MAX) ? LEN_MAX : i_prog_len;
    assign w_last    = ({1'b0, r_pc} == (r_len - LEN_ONE));

    seq_prog_store #(
        .PROG_DEPTH (PROG_DEPTH),
        .PC_W       (PC_W)
    ) u_store (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_we),
        .i_waddr (i_prog_addr),
        .i_wdata (i_prog_wdata),
        .i_raddr (r_pc),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_state_n  = r_state;
        w_pc_n     = r_pc;
        w_len_n    = r_len;
        w_loop_n   = r_loop;
        w_instr_n  = NOP_INSTR;
        w_valid_n  = 1'b0;
        w_done_n   = 1'b0;
        w_halted_n = r_halted;
        w_err_n    = i_prog_we && (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_halted_n = 1'b0;
                    w_pc_n     = '0;
                    w_len_n    = w_len_sat;
                    w_loop_n   = i_loop_en;
                    w_state_n  = (w_len_sat == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    w_state_n = S_IDLE;
                    w_pc_n    = '0;
                end else if (i_hold) begin
                    w_pc_n = r_pc;
                end else if (w_rdata[15:12] == OPC_HALT) begin
                    // The HALT word itself is never forwarded to the datapath.
                    w_halted_n = 1'b1;
                    w_state_n  = S_DONE;
                end else begin
                    w_instr_n = w_rdata;
                    w_valid_n = 1'b1;
                    w_pc_n    = r_pc + PC_ONE;
                    if (w_last) begin
                        if (r_loop) begin
                            w_pc_n = '0;
                        end else begin
                            w_state_n = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                w_done_n  = 1'b1;
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_len    <= '0;
            r_loop   <= 1'b0;
            r_instr  <= NOP_INSTR;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_pc     <= w_pc_n;
            r_len    <= w_len_n;
            r_loop   <= w_loop_n;
            r_instr  <= w_instr_n;
            r_valid  <= w_valid_n;
            r_done   <= w_done_n;
            r_halted <= w_halted_n;
            r_err    <= w_err_n;
        end
    end

    assign o_instr_out   = r_instr;
    assign o_instr_valid = r_valid;
    assign o_pc          = r_pc;
    assign o_busy        = (r_state == S_RUN);
    assign o_done        = r_done;
    assign o_halted      = r_halted;
    assign o_prog_err    = r_err;

endmodule

// File: tb/tb_alu_program_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner sequences, random runs vs a trace model.
module tb_alu_program_sequencer;

    localparam logic [15:0] NOP = 16'h5000;

    logic        clk;
    logic        rst_n;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [15:0] prog_wdata;
    logic [4:0]  prog_len;
    logic        start;
    logic        loop_en;
    logic        hold;
    logic        abort;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    logic        halted;
    logic        prog_err;

    int n_pass;
    int n_total;

    alu_program_sequencer #(
        .PROG_DEPTH (16),
        .PC_W       (4)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_prog_we     (prog_we),
        .i_prog_addr   (prog_addr),
        .i_prog_wdata  (prog_wdata),
        .i_prog_len    (prog_len),
        .i_start       (start),
        .i_loop_en     (loop_en),
        .i_hold        (hold),
        .i_abort       (abort),
        .o_instr_out   (instr_out),
        .o_instr_valid (instr_valid),
        .o_pc          (pc),
        .o_busy        (busy),
        .o_done        (done),
        .o_halted      (halted),
        .o_prog_err    (prog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        int          len;
        bit          chk_first;
        logic [15:0] first;
        int          n_valid;
        int          done_cyc;
        bit          halted;
    } vec_t;

    typedef struct {
        logic [15:0] instr;
        logic        valid;
        logic        done;
        logic        busy;
        logic [3:0]  pc;
    } exp_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_slot(input int a, input logic [15:0] w);
        prog_we    = 1'b1;
        prog_addr  = 4'(a);
        prog_wdata = w;
        tick();
        prog_we    = 1'b0;
    endtask

    // Returns just after the edge that samples start (edge T).
    task automatic start_run(input int len, input bit lp);
        prog_len = 5'(len);
        loop_en  = lp;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 60; k++) begin
            if (done) break;
            tick();
        end
        if (k == 60) check("drain_timeout", 32'd0, 32'd1);
        tick();
    endtask

    function automatic exp_t mk(logic [15:0] i, logic v, logic d, logic b, int p);
        exp_t e;
        e.instr = i;
        e.valid = v;
        e.done  = d;
        e.busy  = b;
        e.pc    = 4'(p);
        return e;
    endfunction

    vec_t        vecs[5];
    logic [15:0] prog_m[16];
    bit          hp[200];
    exp_t        q[$];

    initial begin
        int cnt;
        int dcyc;
        logic [15:0] first;
        int len_sat;
        int slot;
        bit halt_m;
        logic [15:0] w;

        n_pass = 0;
        n_total = 0;

        vecs[0] = '{16'h0051, 16'h0032, 16'hB013, 3, 1'b1, 16'h0051, 3, 4, 1'b0};
        vecs[1] = '{16'h0051, 16'h7000, 16'hB013, 4, 1'b1, 16'h0051, 1, 3, 1'b1};
        vecs[2] = '{16'h1111, 16'h2222, 16'h3333, 0, 1'b0, 16'h0000, 0, 1, 1'b0};
        vecs[3] = '{16'h7ABC, 16'h0051, 16'h0032, 2, 1'b0, 16'h0000, 0, 2, 1'b1};
        vecs[4] = '{16'h0051, 16'h0032, 16'hB013, 20, 1'b1, 16'h0051, 16, 17, 1'b0};

        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0; prog_len = '0;
        start = 1'b0; loop_en = 1'b0; hold = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_instr", 32'(instr_out), 32'(NOP));
        check("rst_flags", {27'd0, instr_valid, busy, done, halted, prog_err}, 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed vector table.
        for (int v = 0; v < 5; v++) begin
            write_slot(0, vecs[v].w0);
            write_slot(1, vecs[v].w1);
            write_slot(2, vecs[v].w2);
            start_run(vecs[v].len, 1'b0);
            cnt = 0; dcyc = -1; first = '0;
            for (int k = 1; k <= 40; k++) begin
                tick();
                if (instr_valid) begin
                    if (cnt == 0) first = instr_out;
                    cnt++;
                end
                if (done) begin
                    dcyc = k;
                    break;
                end
            end
            if (vecs[v].chk_first) check($sformatf("vec%0d_first", v), 32'(first), 32'(vecs[v].first));
            check($sformatf("vec%0d_nvalid", v), cnt, vecs[v].n_valid);
            check($sformatf("vec%0d_done_cyc", v), dcyc, vecs[v].done_cyc);
            check($sformatf("vec%0d_halted", v), 32'(halted), 32'(vecs[v].halted));
            tick();
        end

        // Hold for three cycles starting on the second RUN cycle.
        write_slot(0, 16'h0051); write_slot(1, 16'h0032); write_slot(2, 16'hB013);
        start_run(3, 1'b0);
        tick();
        check("hold_w0", {15'd0, instr_valid, instr_out}, {15'd0, 1'b1, 16'h0051});
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("hold_nop%0d", k), {11'd0, pc, instr_valid, instr_out},
                  {11'd0, 4'd1, 1'b0, NOP});
        end
        hold = 1'b0;
        tick();
        check("hold_w1", {15'd0, instr_valid, instr_out}, {15'd0, 1'b1, 16'h0032});
        tick();
        check("hold_w2", {15'd0, instr_valid, instr_out}, {15'd0, 1'b1, 16'hB013});
        tick();
        check("hold_done_t7", 32'(done), 32'd1);
        tick();

        // Looping run, aborted after five issues.
        start_run(2, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("loop_issue%0d", k), {15'd0, instr_valid, instr_out},
                  {15'd0, 1'b1, (k % 2 == 1) ? 16'h0032 : 16'h0051});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_state", {11'd0, pc, busy, instr_valid, done, instr_out[12:0]},
              {11'd0, 4'd0, 1'b0, 1'b0, 1'b0, NOP[12:0]});
        tick();
        check("abort_no_done", {30'd0, done, busy}, 32'd0);

        // Program write during RUN is rejected.
        start_run(3, 1'b0);
        tick();
        prog_we = 1'b1; prog_addr = 4'd1; prog_wdata = 16'h1234;
        tick();
        prog_we = 1'b0;
        check("err_pulse", 32'(prog_err), 32'd1);
        tick();
        check("err_clear", 32'(prog_err), 32'd0);
        drain();
        start_run(3, 1'b0);
        tick(); tick();
        check("err_old_word", 32'(instr_out), 32'h0032);
        drain();

        // Write and start in the same IDLE cycle: the run sees the new word.
        prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = 16'h0077;
        start_run(1, 1'b0);
        prog_we = 1'b0;
        tick();
        check("wr_start_same", {15'd0, instr_valid, instr_out}, {15'd0, 1'b1, 16'h0077});
        drain();

        // Asynchronous reset mid-run clears outputs and program.
        start_run(3, 1'b0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out", {11'd0, instr_valid, busy, done, pc, instr_out},
              {11'd0, 3'd0, 4'd0, NOP});
        @(negedge clk);
        rst_n = 1'b1;
        start_run(3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("postrst_w%0d", k), {15'd0, instr_valid, instr_out}, {15'd0, 1'b1, NOP});
        end
        drain();

        // Random programs, lengths and hold patterns against a trace model.
        for (int r = 0; r < 25; r++) begin
            for (int s = 0; s < 16; s++) begin
                w = 16'($urandom);
                if ($urandom_range(0, 9) == 0) w[15:12] = 4'h7;
                else if (w[15:12] == 4'h7) w[15:12] = 4'h0;
                prog_m[s] = w;
                write_slot(s, w);
            end
            for (int k = 0; k < 200; k++) hp[k] = (k < 100) && ($urandom_range(0, 3) == 0);
            len_sat = $urandom_range(0, 18);
            prog_len = 5'(len_sat);
            if (len_sat > 16) len_sat = 16;

            q.delete();
            slot = 0;
            halt_m = 1'b0;
            if (len_sat == 0) begin
                q.push_back(mk(NOP, 1'b0, 1'b1, 1'b0, 0));
            end else begin
                for (int k = 1; k < 200; k++) begin
                    if (hp[k]) begin
                        q.push_back(mk(NOP, 1'b0, 1'b0, 1'b1, slot));
                    end else if (prog_m[slot][15:12] == 4'h7) begin
                        q.push_back(mk(NOP, 1'b0, 1'b0, 1'b0, slot));
                        q.push_back(mk(NOP, 1'b0, 1'b1, 1'b0, slot));
                        halt_m = 1'b1;
                        break;
                    end else begin
                        q.push_back(mk(prog_m[slot], 1'b1, 1'b0, (slot + 1) != len_sat,
                                       (slot + 1) % 16));
                        if (slot + 1 == len_sat) begin
                            q.push_back(mk(NOP, 1'b0, 1'b1, 1'b0, (slot + 1) % 16));
                            break;
                        end
                        slot++;
                    end
                end
            end

            loop_en = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int i = 0; i < q.size(); i++) begin
                hold = hp[i + 1];
                tick();
                check($sformatf("rnd%0d_cyc%0d", r, i + 1),
                      {9'd0, instr_out, instr_valid, done, busy, pc},
                      {9'd0, q[i].instr, q[i].valid, q[i].done, q[i].busy, q[i].pc});
            end
            hold = 1'b0;
            check($sformatf("rnd%0d_halted", r), 32'(halted), 32'(halt_m));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
